// File: rtl/alu_multicycle.sv
// alu_multicycle: ALU for the execute stage of the multicycle core.
// Single-cycle ops write the result at the start edge. Shifts iterate one
// bit per clock in state SHIFT, so there is no barrel shifter. A start/busy/
// done handshake lets the control FSM stall until the result is valid.
// Optional feature macro: ALU_MUL_EN adds code 1010, an iterative shift-add
// multiply in state MUL. Without it, 1010 returns BAD_RESULT in one cycle.
module alu_multicycle #(
    parameter int          WIDTH      = 32,
    parameter int          SHW        = $clog2(WIDTH),
    parameter logic [31:0] BAD_RESULT = 32'hBAD00BAD
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ALU_START,
    input  logic [3:0]       ALU_FUN,
    input  logic [WIDTH-1:0] ALU_SRC_A,
    input  logic [WIDTH-1:0] ALU_SRC_B,
    output logic             ALU_BUSY,
    output logic             ALU_DONE,
    output logic [WIDTH-1:0] ALU_result,
    output logic             ALU_zero
);
    // The counter must hold WIDTH itself, which the multiply loads.
    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_LUI  = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    localparam logic [WIDTH-1:0] BAD_W = WIDTH'(BAD_RESULT);

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             left_reg, left_next;   // shift direction of the op in flight
    logic             fill_reg, fill_next;   // bit shifted in at the MSB on right shifts
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] mul_sum;
`endif

    logic [WIDTH-1:0] single_result;
    logic [WIDTH-1:0] shift_step;
    logic [SHW-1:0]   shamt;
    logic             start_is_shift;

    assign shamt          = ALU_SRC_B[SHW-1:0];
    assign start_is_shift = (ALU_FUN == OP_SLL) || (ALU_FUN == OP_SRL) || (ALU_FUN == OP_SRA);

    // Result of every op that completes at the start edge (shift by 0 passes A).
    always_comb begin
        single_result = BAD_W;
        case (ALU_FUN)
            OP_ADD:  single_result = ALU_SRC_A + ALU_SRC_B;
            OP_SUB:  single_result = ALU_SRC_A - ALU_SRC_B;
            OP_OR:   single_result = ALU_SRC_A | ALU_SRC_B;
            OP_AND:  single_result = ALU_SRC_A & ALU_SRC_B;
            OP_XOR:  single_result = ALU_SRC_A ^ ALU_SRC_B;
            OP_SLL,
            OP_SRL,
            OP_SRA:  single_result = ALU_SRC_A;
            OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, ($signed(ALU_SRC_A) < $signed(ALU_SRC_B))};
            OP_SLTU: single_result = {{(WIDTH-1){1'b0}}, (ALU_SRC_A < ALU_SRC_B)};
            OP_LUI:  single_result = {ALU_SRC_A[WIDTH-1:12], 12'h000};
            default: single_result = BAD_W;
        endcase
    end

    // One-bit shift network: each bit takes its lower or upper neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            logic from_lower;
            logic from_upper;
            if (gi == 0) begin : g_lsb
                assign from_lower = 1'b0;
            end else begin : g_lo
                assign from_lower = work_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign from_upper = fill_reg;
            end else begin : g_hi
                assign from_upper = work_reg[gi+1];
            end
            assign shift_step[gi] = left_reg ? from_lower : from_upper;
        end
    endgenerate

`ifdef ALU_MUL_EN
    // Partial product for the current multiplier bit.
    assign mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        work_next   = work_reg;
        cnt_next    = cnt_reg;
        left_next   = left_reg;
        fill_next   = fill_reg;
`ifdef ALU_MUL_EN
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (ALU_START) begin
                    if (start_is_shift && (shamt != '0)) begin
                        work_next  = ALU_SRC_A;
                        cnt_next   = {1'b0, shamt};
                        left_next  = (ALU_FUN == OP_SLL);
                        fill_next  = (ALU_FUN == OP_SRA) & ALU_SRC_A[WIDTH-1];
                        state_next = ST_SHIFT;
                    end
`ifdef ALU_MUL_EN
                    else if (ALU_FUN == OP_MUL) begin
                        mcand_next  = ALU_SRC_A;
                        mplier_next = ALU_SRC_B;
                        acc_next    = '0;
                        cnt_next    = CW'(WIDTH);
                        state_next  = ST_MUL;
                    end
`endif
                    else begin
                        result_next = single_result;
                        done_next   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                work_next = shift_step;
                cnt_next  = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    result_next = shift_step;
                    done_next   = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                acc_next    = mul_sum;
                mcand_next  = {mcand_reg[WIDTH-2:0], 1'b0};
                mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
                cnt_next    = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    result_next = mul_sum;
                    done_next   = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers; reset clears the result and suppresses DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_reg <= '0;
            done_reg   <= 1'b0;
            work_reg   <= '0;
            cnt_reg    <= '0;
            left_reg   <= 1'b0;
            fill_reg   <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
`endif
        end else begin
            result_reg <= result_next;
            done_reg   <= done_next;
            work_reg   <= work_next;
            cnt_reg    <= cnt_next;
            left_reg   <= left_next;
            fill_reg   <= fill_next;
`ifdef ALU_MUL_EN
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
`endif
        end
    end

    assign ALU_BUSY   = (state_reg != ST_IDLE);
    assign ALU_DONE   = done_reg;
    assign ALU_result = result_reg;
    assign ALU_zero   = (result_reg == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle: a 32-bit instance for the main
// checks and a 64-bit instance for width-dependent behaviour.
`timescale 1ns/1ps
module tb_alu_multicycle;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_LUI  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  fun = 4'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, zero;
    logic [31:0] result;

    logic        start64 = 1'b0;
    logic [3:0]  fun64 = 4'd0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        busy64, done64, zero64;
    logic [63:0] result64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut (
        .CLK(clk), .RST(rst), .ALU_START(start), .ALU_FUN(fun),
        .ALU_SRC_A(a), .ALU_SRC_B(b), .ALU_BUSY(busy), .ALU_DONE(done),
        .ALU_result(result), .ALU_zero(zero)
    );

    alu_multicycle #(.WIDTH(64)) dut64 (
        .CLK(clk), .RST(rst), .ALU_START(start64), .ALU_FUN(fun64),
        .ALU_SRC_A(a64), .ALU_SRC_B(b64), .ALU_BUSY(busy64), .ALU_DONE(done64),
        .ALU_result(result64), .ALU_zero(zero64)
    );

    // Launch one op on the 32-bit DUT; lat counts edges from the start edge
    // (inclusive) to the edge after which DONE is seen, 0 if it never comes.
    task automatic do_op(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                         input int budget, output logic [31:0] res, output int lat,
                         output int busy_n);
        @(negedge clk);
        fun = f; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_n = 0;
        for (int k = 1; k <= budget; k++) begin
            if (busy) busy_n++;
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        res = result;
        $display("op32 fun=%b a=%h b=%h result=%h latency=%0d busy_cycles=%0d", f, x, y, res, lat, busy_n);
    endtask

    task automatic do_op64(input logic [3:0] f, input logic [63:0] x, input logic [63:0] y,
                           input int budget, output logic [63:0] res, output int lat,
                           output int busy_n);
        @(negedge clk);
        fun64 = f; a64 = x; b64 = y; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        lat = 0; busy_n = 0;
        for (int k = 1; k <= budget; k++) begin
            if (busy64) busy_n++;
            if (done64) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        res = result64;
        $display("op64 fun=%b a=%h b=%h result=%h latency=%0d busy_cycles=%0d", f, x, y, res, lat, busy_n);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int lat, bn, dones;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (result64 !== 64'h0) begin failures++; $display("FAIL reset_result64 got=%h exp=0", result64); end
        rst = 1'b0;
        do_op(OP_ADD, 32'd1, 32'd2, 4, r, lat, bn);
        checks++; if (r !== 32'd3) begin failures++; $display("FAIL pre_reset_add got=%h exp=00000003", r); end
        // sll by 20, then reset asynchronously 5 cycles into SHIFT
        @(negedge clk);
        fun = OP_SLL; a = 32'd1; b = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midshift_busy got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL async_reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL async_reset_result got=%h exp=00000000", result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL async_reset_zero got=%b exp=1", zero); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        $display("reset_abort sll n=20 dones_after_release=%0d", dones);
        checks++; if (dones !== 0) begin failures++; $display("FAIL no_done_after_reset got=%0d exp=0", dones); end
    endtask

    // fun, A, B, expected result for single-cycle ops
    logic [3:0]  sc_fun [0:11] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_LUI, OP_BAD,
                                   OP_OR, OP_AND, OP_XOR, OP_SUB, OP_SLT, OP_SLT};
    logic [31:0] sc_a   [0:11] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345FFF, 32'h0000AAAA,
                                   32'hF0F00000, 32'hFF00FF00, 32'hAAAA5555, 32'd3, 32'd1, 32'h80000000};
    logic [31:0] sc_b   [0:11] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h00000000, 32'h0000BBBB,
                                   32'h00000F0F, 32'h0F0F0F0F, 32'hFFFF0000, 32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] sc_exp [0:11] = '{32'h80000000, 32'h0, 32'h1, 32'h0, 32'h12345000, 32'hBAD00BAD,
                                   32'hF0F00F0F, 32'h0F000F00, 32'h55555555, 32'hFFFFFFFE, 32'h0, 32'h1};

    task automatic test_single_cycle();
        logic [31:0] r;
        int lat, bn;
        for (int i = 0; i < 12; i++) begin
            do_op(sc_fun[i], sc_a[i], sc_b[i], 4, r, lat, bn);
            checks++; if (r !== sc_exp[i]) begin failures++; $display("FAIL single_result[%0d] got=%h exp=%h", i, r, sc_exp[i]); end
            checks++; if (lat !== 1) begin failures++; $display("FAIL single_latency[%0d] got=%0d exp=1", i, lat); end
            checks++; if (bn !== 0) begin failures++; $display("FAIL single_busy[%0d] got=%0d exp=0", i, bn); end
            checks++; if (zero !== (sc_exp[i] == 32'h0)) begin failures++; $display("FAIL single_zero[%0d] got=%b exp=%b", i, zero, (sc_exp[i] == 32'h0)); end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    endtask

    // fun, A, B, expected result, latency, busy cycles for shifts
    logic [3:0]  sh_fun [0:6] = '{OP_SRA, OP_SRL, OP_SLL, OP_SLL, OP_SRL, OP_SRA, OP_SRA};
    logic [31:0] sh_a   [0:6] = '{32'h80000000, 32'h80001234, 32'd1, 32'd3, 32'h80000000, 32'h40000000, 32'hF0000000};
    logic [31:0] sh_b   [0:6] = '{32'd31, 32'd0, 32'd32, 32'd5, 32'd4, 32'd2, 32'd36};
    logic [31:0] sh_exp [0:6] = '{32'hFFFFFFFF, 32'h80001234, 32'd1, 32'h60, 32'h08000000, 32'h10000000, 32'hFF000000};
    int          sh_lat [0:6] = '{32, 1, 1, 6, 5, 3, 5};

    task automatic test_shift();
        logic [31:0] r;
        int lat, bn;
        for (int i = 0; i < 7; i++) begin
            do_op(sh_fun[i], sh_a[i], sh_b[i], 40, r, lat, bn);
            checks++; if (r !== sh_exp[i]) begin failures++; $display("FAIL shift_result[%0d] got=%h exp=%h", i, r, sh_exp[i]); end
            checks++; if (lat !== sh_lat[i]) begin failures++; $display("FAIL shift_latency[%0d] got=%0d exp=%0d", i, lat, sh_lat[i]); end
            checks++; if (bn !== sh_lat[i] - 1) begin failures++; $display("FAIL shift_busy[%0d] got=%0d exp=%0d", i, bn, sh_lat[i] - 1); end
        end
    endtask

    task automatic test_capture();
        logic [31:0] r;
        int dones, first;
        @(negedge clk);
        fun = OP_SRL; a = 32'hF0000000; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; first = 0; r = '0;
        for (int k = 1; k <= 12; k++) begin
            if (done) begin
                dones++;
                if (first == 0) begin
                    first = k;
                    r = result;
                end
            end
            @(negedge clk);
            if (k <= 3) begin
                start = 1'b1; fun = OP_ADD; a = 32'hFFFFFFFF; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        $display("capture srl n=4 with restarts result=%h first_done=%0d dones=%0d", r, first, dones);
        checks++; if (r !== 32'h0F000000) begin failures++; $display("FAIL capture_result got=%h exp=0F000000", r); end
        checks++; if (first !== 5) begin failures++; $display("FAIL capture_latency got=%0d exp=5", first); end
        checks++; if (dones !== 1) begin failures++; $display("FAIL capture_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int lat, bn;
        do_op(OP_SLL, 32'd1, 32'd2, 10, r, lat, bn);
        checks++; if (r !== 32'd4 || lat !== 3) begin failures++; $display("FAIL b2b_first got=%h/%0d exp=00000004/3", r, lat); end
        // DONE is high now: hold START with add 2+3
        start = 1'b1; fun = OP_ADD; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        $display("b2b add 2+3 done=%b result=%h", done, result);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_second_done got=%b exp=1", done); end
        checks++; if (result !== 32'd5) begin failures++; $display("FAIL b2b_second_result got=%h exp=00000005", result); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
    endtask

    task automatic test_width64();
        logic [63:0] r;
        int lat, bn;
        do_op64(OP_SLL, 64'd1, 64'd63, 80, r, lat, bn);
        checks++; if (r !== 64'h8000000000000000) begin failures++; $display("FAIL w64_sll_result got=%h exp=8000000000000000", r); end
        checks++; if (lat !== 64) begin failures++; $display("FAIL w64_sll_latency got=%0d exp=64", lat); end
        checks++; if (bn !== 63) begin failures++; $display("FAIL w64_sll_busy got=%0d exp=63", bn); end
        do_op64(OP_ADD, 64'hFFFFFFFFFFFFFFFF, 64'd1, 4, r, lat, bn);
        checks++; if (r !== 64'h0) begin failures++; $display("FAIL w64_add_wrap got=%h exp=0", r); end
        checks++; if (zero64 !== 1'b1) begin failures++; $display("FAIL w64_zero got=%b exp=1", zero64); end
        do_op64(OP_BAD, 64'd7, 64'd9, 4, r, lat, bn);
        checks++; if (r !== 64'h00000000BAD00BAD) begin failures++; $display("FAIL w64_bad got=%h exp=00000000bad00bad", r); end
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int lat, bn;
`ifdef ALU_MUL_EN
        do_op(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 40, r, lat, bn);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL mul_max_result got=%h exp=00000001", r); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL mul_max_latency got=%0d exp=33", lat); end
        checks++; if (bn !== 32) begin failures++; $display("FAIL mul_max_busy got=%0d exp=32", bn); end
        do_op(OP_MUL, 32'd3, 32'd7, 40, r, lat, bn);
        checks++; if (r !== 32'd21) begin failures++; $display("FAIL mul_3x7_result got=%h exp=00000015", r); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL mul_3x7_latency got=%0d exp=33", lat); end
`else
        do_op(OP_MUL, 32'd3, 32'd7, 40, r, lat, bn);
        checks++; if (r !== 32'hBAD00BAD) begin failures++; $display("FAIL mul_off_result got=%h exp=bad00bad", r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL mul_off_latency got=%0d exp=1", lat); end
        checks++; if (bn !== 0) begin failures++; $display("FAIL mul_off_busy got=%0d exp=0", bn); end
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_single_cycle();
        test_shift();
        test_capture();
        test_back_to_back();
        test_width64();
        test_mul();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised successor to the single-cycle ALU, sitting in the execute stage of the multicycle core.
- Restores the full RV32I operation set; datapath width is a parameter.
- Shifts run iteratively, one bit per clock, instead of through a barrel shifter.
- Start/busy/done handshake lets the control FSM stall until the result is valid; the result is registered.

Parameters:
WIDTH, 32, datapath width in bits; must be ≥ 13 and a power of two
SHW, $clog2(WIDTH), shift-amount width taken from ALU_SRC_B[SHW-1:0]
BAD_RESULT, 32'hBAD00BAD, result for an unused ALU_FUN code; zero-extended or truncated to WIDTH

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
ALU_START  in  1  start request; sampled on the CLK edge, honoured only when ALU_BUSY=0
ALU_FUN  in  4  operation code, captured at start
ALU_SRC_A  in  WIDTH  operand A, captured at start
ALU_SRC_B  in  WIDTH  operand B, captured at start
ALU_BUSY  out  1  operation in progress; new starts are ignored
ALU_DONE  out  1  one-cycle pulse: ALU_result has just been updated
ALU_result  out  WIDTH  registered result; holds its value until the next completion
ALU_zero  out  1  combinational (ALU_result == 0)

Behaviour:
- Clock and reset: single CLK domain. RST is asynchronous and active-high. While RST is high: state=IDLE, ALU_result=0, ALU_DONE=0, ALU_BUSY=0, ALU_zero=1.
- Reset mid-operation: aborts the operation and no DONE is produced.
- Operation codes:
  - 0000 add; 1000 sub (both modulo 2^WIDTH)
  - 0110 or; 0111 and; 0100 xor
  - 0001 sll; 0101 srl; 1101 sra (shift amount = B[SHW-1:0])
  - 0010 slt (signed compare); 0011 sltu (unsigned compare); both produce 0 or 1, zero-extended
  - 1001 lui-copy: A with bits [11:0] cleared
  - Any other code: BAD_RESULT, single-cycle
- Operand capture: A, B and FUN are captured at the start edge. Later input changes have no effect on the operation in flight.
- States: IDLE, SHIFT, (MUL when the optional feature is enabled).
- IDLE, start with a single-cycle op or a shift with n=0:
  - Result is written at the start edge.
  - ALU_DONE=1 in the next cycle (latency 1).
  - State stays IDLE; ALU_BUSY stays 0.
- IDLE, start with a shift with n≥1:
  - Working register loads A, counter loads n, state goes to SHIFT.
  - Each SHIFT edge shifts one bit (sra fills with the captured A[WIDTH-1]) and decrements the counter.
  - On the edge where the counter reaches 0: ALU_result = working register, ALU_DONE=1, state goes to IDLE.
  - Latency = n+1 cycles from the start edge. ALU_BUSY=1 for exactly n cycles.
- ALU_DONE is high for exactly one cycle per accepted operation.
- Back-to-back: ALU_START high in the DONE cycle is accepted, because the state is already IDLE.
- ALU_START while ALU_BUSY=1 is ignored silently; it is not queued.
- ALU_result changes only on a completion edge or on reset.

Optional Feature:
ALU_MUL_EN
- Defined:
  - Code 1010 = multiply, result = low WIDTH bits of A*B.
  - Computed by iterative shift-add in state MUL, one multiplier bit per cycle, WIDTH cycles.
  - ALU_BUSY=1 for WIDTH cycles; DONE arrives at latency WIDTH+1, independent of the operand values.
- Undefined: the MUL state and its datapath are absent, and 1010 returns BAD_RESULT in a single cycle.

Test Plan:
- Reset: assert RST mid-SHIFT (sll, n=20, after 5 cycles) -> BUSY=0, DONE=0, result=0, zero=1 immediately, with no CLK edge required; no DONE pulse after RST is released.
- Single-cycle ops: add 0x7FFFFFFF+1 -> 0x80000000, latency 1, BUSY never high; sub 5-5 -> 0, zero=1; slt 0xFFFFFFFF,1 -> 1; sltu 0xFFFFFFFF,1 -> 0; lui-copy 0x12345FFF -> 0x12345000; code 1111 -> 0xBAD00BAD.
- Shifts: sra 0x80000000 by 31 -> 0xFFFFFFFF with DONE at latency 32 and BUSY high for 31 cycles; srl by 0 -> A at latency 1; sll 1 by 32 (B=32, shift amount field=0) -> 1 at latency 1.
- Handshake: start srl n=4, toggle A/B/FUN and pulse START during BUSY -> result uses the captured operands and only one DONE pulse; START held in the DONE cycle with add 2+3 -> second DONE one cycle later, result 5.
- Width: WIDTH=64, sll 1 by 63 -> 0x8000000000000000 at latency 64; add wrap 0xFFFF_FFFF_FFFF_FFFF+1 -> 0, zero=1.
- ALU_MUL_EN: 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001, DONE at latency 33; 3*7 -> 21; with the macro undefined, 1010 -> 0xBAD00BAD at latency 1.
